// File: rtl/pcm_to_pdm.sv
// Multi-channel PDM microphone emulator: PCM samples in, one first-order
// sigma-delta bit per channel out on each rising edge of pdm_clk.
module pcm_to_pdm #(
    parameter int BIT_WIDTH = 16,
    parameter int NUM_MICS  = 9,
    parameter int OSR       = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 pdm_clk,
    output logic [NUM_MICS-1:0]  pdm,
    input  logic [BIT_WIDTH-1:0] pcm_data,
    input  logic [4:0]           pcm_ch,
    input  logic                 pcm_valid,
    output logic                 pcm_ready,
    output logic                 frame_strobe,
    output logic [NUM_MICS-1:0]  underrun,
    input  logic                 underrun_clr
);

    localparam int FW = $clog2(OSR);
    localparam logic [FW-1:0] FLAST = FW'(OSR - 1);

    logic                 pdm_clk_q;
    logic [FW-1:0]        fcnt_q;
    logic [FW-1:0]        fcnt_d;
    logic [BIT_WIDTH-1:0] pend_q   [NUM_MICS];
    logic [BIT_WIDTH-1:0] active_q [NUM_MICS];
    logic [BIT_WIDTH:0]   acc_q    [NUM_MICS];
    logic [BIT_WIDTH:0]   acc_d    [NUM_MICS];
    logic [BIT_WIDTH:0]   sum      [NUM_MICS];
    logic [NUM_MICS-1:0]  pend_vld_q;
    logic [NUM_MICS-1:0]  pdm_q;
    logic [NUM_MICS-1:0]  pdm_d;
    logic [NUM_MICS-1:0]  urun_q;
    logic [NUM_MICS-1:0]  urun_d;
    logic                 fstb_q;

    logic        tick;
    logic        bnd;
    logic        in_rng;
    logic        accept;
    logic [31:0] pv_ext;

    assign tick   = pdm_clk & ~pdm_clk_q;
    assign bnd    = tick & (fcnt_q == FLAST);
    assign in_rng = 32'(pcm_ch) < NUM_MICS;
    assign pv_ext = 32'(pend_vld_q);

    // Out-of-range channels are always ready so a stray write never stalls.
    assign pcm_ready = in_rng ? ~pv_ext[pcm_ch] : 1'b1;
    assign accept    = pcm_valid & pcm_ready & in_rng;

    assign fcnt_d = bnd ? '0 : fcnt_q + FW'(1);

    // Offset-binary input (MSB flipped) added into the accumulator;
    // the carry out is the PDM bit and is dropped from the accumulator.
    always_comb begin
        for (int i = 0; i < NUM_MICS; i++) begin
            sum[i] = acc_q[i] + {1'b0, ~active_q[i][BIT_WIDTH-1],
                                 active_q[i][BIT_WIDTH-2:0]};
            pdm_d[i]  = sum[i][BIT_WIDTH];
            acc_d[i]  = {1'b0, sum[i][BIT_WIDTH-1:0]};
            urun_d[i] = (bnd & ~pend_vld_q[i])
                      | (urun_q[i] & ~underrun_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pdm_clk_q  <= 1'b1;
            fcnt_q     <= '0;
            fstb_q     <= 1'b0;
            pdm_q      <= '0;
            urun_q     <= '0;
            pend_vld_q <= '0;
            for (int i = 0; i < NUM_MICS; i++) begin
                pend_q[i]   <= '0;
                active_q[i] <= '0;
                acc_q[i]    <= '0;
            end
        end else begin
            pdm_clk_q <= pdm_clk;
            fstb_q    <= bnd;
            urun_q    <= urun_d;
            if (tick) begin
                fcnt_q <= fcnt_d;
                pdm_q  <= pdm_d;
            end
            for (int i = 0; i < NUM_MICS; i++) begin
                if (tick)
                    acc_q[i] <= acc_d[i];
                if (bnd && pend_vld_q[i]) begin
                    active_q[i]   <= pend_q[i];
                    pend_vld_q[i] <= 1'b0;
                end else if (accept && pcm_ch == 5'(i)) begin
                    pend_q[i]     <= pcm_data;
                    pend_vld_q[i] <= 1'b1;
                end
            end
        end
    end

    assign pdm          = pdm_q;
    assign frame_strobe = fstb_q;
    assign underrun     = urun_q;

endmodule

// File: tb/tb_pcm_to_pdm.sv
// Directed bench for pcm_to_pdm: bit patterns, frame boundary,
// write handshake, underrun flags and mid-frame reset.
module tb_pcm_to_pdm;

    localparam int ALT = 0;
    localparam int ZER = 1;
    localparam int P34 = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        pdm_clk = 1'b0;
    logic        pcm_valid = 1'b0;
    logic        underrun_clr = 1'b0;
    logic [4:0]  pcm_ch = 5'd0;
    logic [15:0] pcm_data = 16'h0;
    logic [8:0]  pdm;
    logic [8:0]  underrun;
    logic        pcm_ready;
    logic        frame_strobe;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pcm_to_pdm dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pdm_clk      (pdm_clk),
        .pdm          (pdm),
        .pcm_data     (pcm_data),
        .pcm_ch       (pcm_ch),
        .pcm_valid    (pcm_valid),
        .pcm_ready    (pcm_ready),
        .frame_strobe (frame_strobe),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected bit at tick j of a frame that started with acc = 0.
    function automatic logic pat(input int j, input int m);
        case (m)
            ALT:     return (j % 2) == 0;
            ZER:     return 1'b0;
            default: return (j % 4) != 1;
        endcase
    endfunction

    function automatic logic [8:0] exp_pdm(input int j, input int m0,
                                           input int m2, input int m5);
        logic [8:0] e;
        e    = ((j % 2) == 0) ? 9'h1FF : 9'h000;
        e[0] = pat(j, m0);
        e[2] = pat(j, m2);
        e[5] = pat(j, m5);
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after the tick edge.
    task automatic tick_rise();
        pdm_clk = 1'b1;
        @(negedge clk);
    endtask

    task automatic tick_rest();
        repeat (11) @(negedge clk);
        pdm_clk = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic run_ticks(input int a, input int b, input int m0,
                             input int m2, input int m5);
        for (int j = a; j <= b; j++) begin
            tick_rise();
            chk("pdm", 32'(pdm), 32'(exp_pdm(j, m0, m2, m5)));
            chk("fstrobe", 32'(frame_strobe), 32'(0));
            tick_rest();
        end
    endtask

    task automatic pcm_write(input int ch, input logic [15:0] d,
                             input logic rdy);
        pcm_ch    = 5'(ch);
        pcm_data  = d;
        pcm_valid = 1'b1;
        #1;
        chk("wr_ready", 32'(pcm_ready), 32'(rdy));
        @(negedge clk);
        pcm_valid = 1'b0;
    endtask

    task automatic clr_urun();
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        chk("urun_clr", 32'(underrun), 32'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_pdm", 32'(pdm), 32'(0));
        chk("rst_fstb", 32'(frame_strobe), 32'(0));
        chk("rst_urun", 32'(underrun), 32'(0));
        chk("rst_ready", 32'(pcm_ready), 32'(1));

        // Frame 1: no writes, all channels alternate
        run_ticks(1, 63, ALT, ALT, ALT);
        tick_rise();
        chk("f1_pdm", 32'(pdm), 32'h1FF);
        chk("f1_fstb", 32'(frame_strobe), 32'(1));
        chk("f1_urun", 32'(underrun), 32'h1FF);
        @(negedge clk);
        chk("f1_fstb_end", 32'(frame_strobe), 32'(0));
        tick_rest();
        clr_urun();

        // Frame 2: loads for ch0/ch2, back-to-back ch2, out-of-range
        pcm_write(0, 16'h4000, 1'b1);
        pcm_write(2, 16'h8000, 1'b1);
        pcm_write(2, 16'h1111, 1'b0);
        pcm_write(12, 16'h7FFF, 1'b1);
        pcm_ch = 5'd1;
        #1;
        chk("ch1_ready", 32'(pcm_ready), 32'(1));
        pcm_ch = 5'd0;
        #1;
        chk("ch0_busy", 32'(pcm_ready), 32'(0));
        run_ticks(1, 63, ALT, ALT, ALT);
        pcm_ch = 5'd2;
        #1;
        chk("ch2_busy", 32'(pcm_ready), 32'(0));
        tick_rise();
        chk("f2_pdm", 32'(pdm), 32'h1FF);
        chk("f2_fstb", 32'(frame_strobe), 32'(1));
        chk("f2_urun", 32'(underrun), 32'h1FA);
        chk("ch2_free", 32'(pcm_ready), 32'(1));
        tick_rest();
        clr_urun();
        pcm_write(2, 16'h4000, 1'b1);

        // Frame 3: ch0 = 3/4 density, ch2 all zeros
        run_ticks(1, 63, P34, ZER, ALT);
        pcm_ch       = 5'd5;
        pcm_data     = 16'h8000;
        pcm_valid    = 1'b1;
        underrun_clr = 1'b1;
        #1;
        chk("bnd_ready5", 32'(pcm_ready), 32'(1));
        tick_rise();
        pcm_valid    = 1'b0;
        underrun_clr = 1'b0;
        chk("f3_pdm", 32'(pdm), 32'h1FB);
        chk("f3_fstb", 32'(frame_strobe), 32'(1));
        chk("f3_urun", 32'(underrun), 32'h1FB);
        #1;
        chk("ch5_held", 32'(pcm_ready), 32'(0));
        tick_rest();
        clr_urun();

        // Frame 4: second ch2 sample active, ch5 still on old sample
        run_ticks(1, 63, P34, P34, ALT);
        pcm_ch = 5'd5;
        #1;
        chk("ch5_busy", 32'(pcm_ready), 32'(0));
        tick_rise();
        chk("f4_pdm", 32'(pdm), 32'h1FF);
        chk("f4_fstb", 32'(frame_strobe), 32'(1));
        chk("f4_urun", 32'(underrun), 32'h1DF);
        #1;
        chk("ch5_free", 32'(pcm_ready), 32'(1));
        tick_rest();

        // Frame 5: reset at fcnt = 30 with a pending sample
        pcm_write(1, 16'h1111, 1'b1);
        run_ticks(1, 30, P34, P34, ZER);
        reset_n = 1'b0;
        pdm_clk = 1'b1;
        pcm_ch  = 5'd1;
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst2_pdm", 32'(pdm), 32'(0));
        chk("rst2_fstb", 32'(frame_strobe), 32'(0));
        chk("rst2_urun", 32'(underrun), 32'(0));
        chk("rst2_ready", 32'(pcm_ready), 32'(1));
        repeat (10) @(negedge clk);
        pdm_clk = 1'b0;
        repeat (12) @(negedge clk);

        // Frame 6: fresh frame, boundary exactly 64 ticks later
        run_ticks(1, 63, ALT, ALT, ALT);
        tick_rise();
        chk("f6_pdm", 32'(pdm), 32'h1FF);
        chk("f6_fstb", 32'(frame_strobe), 32'(1));
        chk("f6_urun", 32'(underrun), 32'h1FF);
        tick_rest();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
